// File: rtl/window_28_5x5.sv
// -----------------------------------------------------------------------------
// window_28_5x5
// Sliding 5x5 window generator for a square raster image of signed pixels.
// Every valid KxK window is emitted as a packed word together with a one-cycle
// strobe that starts the downstream 5x5 binary-weight convolution filter.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   reset      - synchronous, active-high reset
//   in         - signed pixel, raster order (row 0 col 0 first)
//   in_valid   - pixel on `in` is valid
//   in_ready   - block accepts a pixel this cycle (low the cycle after a
//                window strobe, which paces strobes at least 2 cycles apart)
//   win_out    - packed window, row-major, top-left pixel in the MSBs
//   win_valid  - one-cycle strobe: win_out holds a new window
//   frame_done - one-cycle strobe with win_valid for the last window of a frame
// -----------------------------------------------------------------------------
module window_28_5x5 #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int DW    = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [DW-1:0]   in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [K*K*DW-1:0]      win_out,
  output logic                   win_valid,
  output logic                   frame_done
);

  localparam int             CW   = $clog2(IMG_W);
  localparam logic [CW-1:0]  LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  EDGE = CW'(K - 1);

  logic [CW-1:0]        row_p0;
  logic [CW-1:0]        col_p0;
  logic                 accept;
  logic                 emit;

  // lb_p0[0] holds the oldest buffered row (r-4), lb_p0[K-2] the row above (r-1)
  logic signed [DW-1:0] lb_p0   [K-1][IMG_W];
  logic signed [DW-1:0] win_p0  [K][K];
  logic signed [DW-1:0] nxt_win [K][K];
  logic [K*K*DW-1:0]    nxt_flat;

  assign in_ready = !reset && !win_valid;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (row_p0 >= EDGE) && (col_p0 >= EDGE);

  // Window as it will look after this pixel is shifted in: existing columns
  // move left by one, the new right column is the buffered column plus `in`.
  always_comb begin
    nxt_win = '{default: '0};
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        nxt_win[i][j] = win_p0[i][j+1];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      nxt_win[i][K-1] = lb_p0[i][col_p0];
    end
    nxt_win[K-1][K-1] = in;
  end

  always_comb begin
    nxt_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        nxt_flat[K*K*DW-1 - DW*(K*i+j) -: DW] = nxt_win[i][j];
      end
    end
  end

  // ---- stage p0: position counters and window/line-buffer shift ----
  always_ff @(posedge clk) begin
    if (reset) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (accept) begin
      if (col_p0 == LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Data storage is not reset: emission needs r >= K-1 and c >= K-1, by which
  // point every line-buffer entry and window column has been rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++) begin
        lb_p0[i][col_p0] <= lb_p0[i+1][col_p0];
      end
      lb_p0[K-2][col_p0] <= in;
      win_p0             <= nxt_win;
    end
  end

  // ---- stage p1: registered window output and strobes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= accept && (row_p0 == LAST) && (col_p0 == LAST);
      if (emit) begin
        win_out <= nxt_flat;
      end
    end
  end

endmodule

// File: tb/tb_window_28_5x5.sv
// -----------------------------------------------------------------------------
// tb_window_28_5x5
// Directed bench for window_28_5x5. A cycle-level reference model tracks the
// expected pixel position, the frame image and the expected registered outputs;
// each cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_window_28_5x5;

  localparam int IMG_W = 28;
  localparam int K     = 5;
  localparam int DW    = 9;
  localparam int WW    = K*K*DW;
  localparam int NPIX  = IMG_W*IMG_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_px;
  logic                 in_valid;
  logic                 in_ready;
  logic [WW-1:0]        win_out;
  logic                 win_valid;
  logic                 frame_done;

  window_28_5x5 #(.IMG_W(IMG_W), .K(K), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_px),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // reference model state
  logic [DW-1:0] img [IMG_W][IMG_W];
  int            mr = 0, mc = 0;
  logic          exp_wv = 1'b0, exp_fd = 1'b0;
  logic [WW-1:0] exp_win = '0;
  int            accepted = 0, wins = 0, fdones = 0;
  int            cyc = 0, last_wv = -10;
  int            mode = 0, phase = 0;
  bit            first_pending = 1'b0, f2_pending = 1'b0;

  function automatic logic [DW-1:0] pixel_for(input int r, input int c);
    case (mode)
      0:       pixel_for = DW'(c - r);
      1:       pixel_for = DW'((r*IMG_W + c) % 512);
      default: pixel_for = 9'h100 | DW'(c);
    endcase
  endfunction

  // One clock cycle: drive inputs, check registered outputs, advance model.
  task automatic cycle(input bit rst, input bit v);
    logic [DW-1:0] px;
    logic [WW-1:0] nw;
    bit            acc, nv, nf, all8;
    px       = pixel_for(mr, mc);
    reset    = rst;
    in_valid = v;
    in_px    = v ? px : DW'($urandom);
    #1;
    check("win_valid", win_valid, exp_wv);
    check("frame_done", frame_done, exp_fd);
    check("win_out", win_out, exp_win);
    check("in_ready", in_ready, !rst && !exp_wv);
    if (win_valid) begin
      wins++;
      check("pace_gap_ge2", (cyc - last_wv) >= 2, 1'b1);
      last_wv = cyc;
      if (first_pending) begin
        first_pending = 1'b0;
        check("first_win_after_px116", accepted, 117);
        if (phase == 2) begin
          check("t2_tl", win_out[224:216], 9'h000);
          check("t2_br", win_out[8:0], 9'h000);
          check("t2_r0c4", win_out[188:180], 9'h004);
          check("t2_r4c0", win_out[44:36], 9'h1FC);
        end
      end
      if (f2_pending && !frame_done) begin
        f2_pending = 1'b0;
        all8 = 1'b1;
        for (int k = 0; k < K*K; k++) all8 &= win_out[DW*k + DW-1];
        check("f2_first_bit8", all8, 1'b1);
        check("f2_first_idx", accepted, 117);
      end
    end
    if (frame_done) begin
      fdones++;
      if (phase == 3) begin
        check("t3_last_br", win_out[8:0], 9'h000);
        check("t3_last_tl", win_out[224:216], 9'h000);
      end
    end
    acc = v && !rst && !exp_wv;
    nv  = 1'b0;
    nf  = 1'b0;
    nw  = exp_win;
    if (rst) begin
      mr = 0; mc = 0; nw = '0;
    end else if (acc) begin
      img[mr][mc] = px;
      accepted++;
      if (mr >= K-1 && mc >= K-1) begin
        nv = 1'b1;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            nw[WW-1 - DW*(K*i+j) -: DW] = img[mr-K+1+i][mc-K+1+j];
      end
      nf = (mr == IMG_W-1) && (mc == IMG_W-1);
      if (mc == IMG_W-1) begin
        mc = 0;
        mr = (mr == IMG_W-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    exp_wv  = nv;
    exp_fd  = nf;
    exp_win = nw;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stream until `npix` pixels are accepted (bounded), optionally with idle tail.
  task automatic run_px(input int npix, input int duty, input bit tail);
    int guard;
    guard    = 0;
    accepted = 0;
    while (accepted < npix && guard < 6000) begin
      cycle(1'b0, $urandom_range(99) < duty);
      guard++;
    end
    check("stream_not_stalled", accepted, npix);
    if (tail) begin
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_px    = '0;
    @(posedge clk);
    #1;

    // 1: reset held with in_valid high
    phase = 1;
    repeat (3) cycle(1'b1, 1'b1);

    // 2+3: c-r pattern, full frame, in_valid always high
    phase = 2; mode = 0; wins = 0; fdones = 0; first_pending = 1'b1;
    run_px(NPIX, 100, 1'b0);
    phase = 3;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("t3_win_count", wins, 576);
    check("t3_frame_done_count", fdones, 1);

    // 4: 50% source stalls
    phase = 4; mode = 1; wins = 0; fdones = 0; first_pending = 1'b1;
    run_px(NPIX, 50, 1'b1);
    check("t4_win_count", wins, 576);
    check("t4_frame_done_count", fdones, 1);

    // 5: reset after pixel 300, then a fresh frame
    phase = 5; mode = 1;
    run_px(301, 100, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    mode = 0; wins = 0; fdones = 0; first_pending = 1'b1;
    run_px(NPIX, 100, 1'b1);
    check("t5_win_count", wins, 576);
    check("t5_frame_done_count", fdones, 1);

    // 6: two frames back-to-back
    phase = 6; mode = 0; wins = 0; fdones = 0;
    run_px(NPIX, 100, 1'b0);
    mode = 2; f2_pending = 1'b1;
    run_px(NPIX, 100, 1'b1);
    check("t6_win_count", wins, 1152);
    check("t6_frame_done_count", fdones, 2);
    check("t6_f2_window_seen", f2_pending, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
